// File: rtl/branch_ctrl_pkg.sv
// Core-wide shared definitions for branch resolution: datapath width,
// conditional-branch funct3 encodings and the branch_ctrl FSM states.
package branch_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EVAL  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // 010/011 are the only unassigned conditional-branch encodings
   function automatic logic f3_is_illegal(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational operand comparator: equality plus signed/unsigned less-than.
module branch_cond_eval #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             eq,
   output logic             lt
);

   always_comb begin
      eq = (a == b);
      if (is_signed) lt = ($signed(a) < $signed(b));
      else           lt = (a < b);
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: captures one op, evaluates it in a single
// EVAL cycle, redirects fetch on mispredict and then holds a flush window.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN         = branch_ctrl_pkg::XLEN,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic            in_is_jal,
   input  logic            in_is_jalr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred_taken,
   output logic            out_valid,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_link,
   output logic            out_illegal,
   output logic            out_misalign,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
);

   localparam int              LOAD_I   = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             is_jal_q, is_jal_d;
   logic             is_jalr_q, is_jalr_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  rs1_q, rs1_d;
   logic [XLEN-1:0]  rs2_q, rs2_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic             pred_q, pred_d;

   logic            cmp_eq, cmp_lt;
   logic            is_jump, cond_taken, illegal, taken, misalign, mispredict;
   logic [XLEN-1:0] target, link;

   // BLT/BGE (1xx with bit1 clear) compare signed; BLTU/BGEU unsigned
   branch_cond_eval #(.WIDTH(XLEN)) u_cond (
      .a         (rs1_q),
      .b         (rs2_q),
      .is_signed (~funct3_q[1]),
      .eq        (cmp_eq),
      .lt        (cmp_lt)
   );

   always_comb begin
      is_jump = is_jal_q | is_jalr_q;
      unique case (funct3_q)
         F3_BEQ:  cond_taken = cmp_eq;
         F3_BNE:  cond_taken = ~cmp_eq;
         F3_BLT:  cond_taken = cmp_lt;
         F3_BGE:  cond_taken = ~cmp_lt;
         F3_BLTU: cond_taken = cmp_lt;
         F3_BGEU: cond_taken = ~cmp_lt;
         default: cond_taken = 1'b0;
      endcase
      illegal = ~is_jump & f3_is_illegal(funct3_q);
      taken   = is_jump | cond_taken;
      // JAL wins when decode flags both jump kinds
      if (is_jalr_q && !is_jal_q) target = (rs1_q + imm_q) & ~XLEN'(1);
      else                        target = pc_q + imm_q;
      link       = pc_q + XLEN'(4);
      misalign   = taken & target[1];
      mispredict = ~illegal & ~misalign & (taken != pred_q);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      funct3_d  = funct3_q;
      is_jal_d  = is_jal_q;
      is_jalr_d = is_jalr_q;
      pc_d      = pc_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      imm_d     = imm_q;
      pred_d    = pred_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               funct3_d  = in_funct3;
               is_jal_d  = in_is_jal;
               is_jalr_d = in_is_jalr;
               pc_d      = in_pc;
               rs1_d     = in_rs1;
               rs2_d     = in_rs2;
               imm_d     = in_imm;
               pred_d    = in_pred_taken;
               state_d   = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (mispredict && FLUSH_CYCLES > 0) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         funct3_q  <= '0;
         is_jal_q  <= 1'b0;
         is_jalr_q <= 1'b0;
         pc_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         pred_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         funct3_q  <= funct3_d;
         is_jal_q  <= is_jal_d;
         is_jalr_q <= is_jalr_d;
         pc_q      <= pc_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
         pred_q    <= pred_d;
      end
   end

   // Result outputs are only meaningful during the single EVAL cycle
   always_comb begin
      in_ready     = (state_q == ST_IDLE);
      flush        = (state_q == ST_FLUSH);
      out_valid    = 1'b0;
      out_taken    = 1'b0;
      out_target   = '0;
      out_link     = '0;
      out_illegal  = 1'b0;
      out_misalign = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;
      if (state_q == ST_EVAL) begin
         out_valid    = 1'b1;
         out_taken    = taken;
         out_target   = target;
         out_link     = link;
         out_illegal  = illegal;
         out_misalign = misalign;
         redirect     = mispredict;
         if (mispredict) redirect_pc = taken ? target : link;
      end
   end

endmodule
